// File: rtl/vga_scan_gen.sv
// Raster timing generator: pixel-rate divider, X/Y scan counters and registered
// sync/blank/frame-start outputs aligned with the presented coordinates.
module vga_scan_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] Q_X,
    output logic [9:0] Q_Y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pix_tick,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_geometry
            $error("vga_scan_gen: H_TOTAL/V_TOTAL must be <= 1024 and CLK_DIV >= 1");
        end
    endgenerate

    // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
    localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] X_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             div_last;
    logic             x_end, y_end;
    logic [9:0]       x_nxt, y_nxt;
    logic             hs_act, vs_act, vo_nxt;

    assign div_last = (div == DIV_LAST);
    assign pix_tick = en && !rst && div_last;
    assign x_end    = (Q_X == X_LAST);
    assign y_end    = (Q_Y == Y_LAST);

    always_comb begin
        x_nxt = Q_X;
        y_nxt = Q_Y;
        if (pix_tick) begin
            if (x_end) begin
                x_nxt = '0;
                y_nxt = y_end ? 10'd0 : Q_Y + 10'd1;
            end else begin
                x_nxt = Q_X + 10'd1;
            end
        end
    end

    // Decode from next-state so the registered flags match the registered coordinates
    assign hs_act = ({1'b0, x_nxt} >= HS_START) && ({1'b0, x_nxt} < HS_END);
    assign vs_act = ({1'b0, y_nxt} >= VS_START) && ({1'b0, y_nxt} < VS_END);
    assign vo_nxt = ({1'b0, x_nxt} < X_ACT) && ({1'b0, y_nxt} < Y_ACT);

    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            Q_X         <= '0;
            Q_Y         <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            if (en)
                div <= div_last ? '0 : div + 1'b1;
            Q_X         <= x_nxt;
            Q_Y         <= y_nxt;
            hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
            video_on    <= vo_nxt;
            frame_start <= pix_tick && x_end && y_end;
        end
    end
endmodule

// File: tb/tb_vga_scan_gen.sv
// Random en/rst stimulus on two scan generators (divided/active-low and
// undivided/active-high) checked against a pixel-index reference model.
module tb_vga_scan_gen;
    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic [9:0] qx_a, qy_a, qx_b, qy_b;
    logic hs_a, vs_a, vo_a, pt_a, fs_a;
    logic hs_b, vs_b, vo_b, pt_b, fs_b;

    int n_tests = 0;
    int n_fail  = 0;

    // model: pixel index since reset, divider phase, frame_start flag
    int mdiv[2];
    int mp[2];
    bit mfs[2];

    always #5 clk = ~clk;

    vga_scan_gen #(.CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0))
    dut_a (.clk(clk), .rst(rst), .en(en), .Q_X(qx_a), .Q_Y(qy_a), .hsync(hs_a),
           .vsync(vs_a), .video_on(vo_a), .pix_tick(pt_a), .frame_start(fs_a));

    vga_scan_gen #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                   .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b1))
    dut_b (.clk(clk), .rst(rst), .en(en), .Q_X(qx_b), .Q_Y(qy_b), .hsync(hs_b),
           .vsync(vs_b), .video_on(vo_b), .pix_tick(pt_b), .frame_start(fs_b));

    function automatic int div_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input int k, input bit r, input bit e);
        bit tick;
        if (r) begin
            mdiv[k] = 0; mp[k] = 0; mfs[k] = 0;
        end else if (e) begin
            tick   = (mdiv[k] == div_of(k) - 1);
            mfs[k] = tick && (mp[k] == FRAME - 1);
            if (tick) begin
                mp[k]   = (mp[k] + 1) % FRAME;
                mdiv[k] = 0;
            end else begin
                mdiv[k] = mdiv[k] + 1;
            end
        end else begin
            mfs[k] = 0;
        end
    endtask

    task automatic chk_dut(input int k, input logic [9:0] qx, input logic [9:0] qy,
                           input logic hs, input logic vs, input logic vo, input logic fs);
        int x, y;
        bit pol;
        x   = mp[k] % HT;
        y   = mp[k] / HT;
        pol = (k == 1);
        chk(k ? "B.x" : "A.x", qx, x);
        chk(k ? "B.y" : "A.y", qy, y);
        chk(k ? "B.hsync" : "A.hsync", hs, (x >= HA + HFP && x < HA + HFP + HS) ? pol : !pol);
        chk(k ? "B.vsync" : "A.vsync", vs, (y >= VA + VFP && y < VA + VFP + VS) ? pol : !pol);
        chk(k ? "B.video_on" : "A.video_on", vo, (x < HA && y < VA) ? 1 : 0);
        chk(k ? "B.frame_start" : "A.frame_start", fs, mfs[k]);
    endtask

    // Called at a negedge: apply inputs, check the tick strobe, clock, check outputs.
    task automatic cycle(input bit r, input bit e);
        rst = r;
        en  = e;
        #1;
        chk("A.pix_tick", pt_a, (e && !r && mdiv[0] == 1) ? 1 : 0);
        chk("B.pix_tick", pt_b, (e && !r) ? 1 : 0);
        @(posedge clk);
        model_edge(0, r, e);
        model_edge(1, r, e);
        @(negedge clk);
        chk_dut(0, qx_a, qy_a, hs_a, vs_a, vo_a, fs_a);
        chk_dut(1, qx_b, qy_b, hs_b, vs_b, vo_b, fs_b);
    endtask

    initial begin
        int cnt_a, cnt_b;
        bit found;
        for (int k = 0; k < 2; k++) begin
            mdiv[k] = 0; mp[k] = 0; mfs[k] = 0;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);

        // two clean frames from reset: frame_start pulse counts
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 2 * FRAME * 2 + 2; i++) begin
            cycle(1'b0, 1'b1);
            if (fs_a) cnt_a++;
            if (fs_b) cnt_b++;
        end
        chk("A.frame_cnt", cnt_a, 2);
        chk("B.frame_cnt", cnt_b, 4);

        // mid-frame reset at a known position of the divided instance
        found = 0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            if (mp[0] == 3 * HT + 5) found = 1;
            else cycle(1'b0, 1'b1);
        end
        chk("seek_pos", found, 1);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);

        // en dropped for 7 cycles with the divider mid-count
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (mdiv[0] == 1) found = 1;
            else cycle(1'b0, 1'b1);
        end
        chk("seek_div", found, 1);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);

        // random en gaps and occasional resets
        for (int i = 0; i < 4000; i++)
            cycle($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
